// File: rtl/md_unit.sv
// Multiply/divide unit for the execute stage: owns HI/LO and runs MULT/MULTU/DIV/DIVU
// as a fixed-latency operation whose result is staged in pend_hi/pend_lo until commit.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        div0_q, div0_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] a_ext_s, b_ext_s, prod_s;
    logic        signed_div_s, a_neg_s, b_neg_s;
    logic [31:0] a_mag_s, b_mag_s, b_safe_s, uquot_s, urem_s, quot_s, rem_s;

    // Arithmetic datapath: product and sign-corrected quotient/remainder from a/b.
    always_comb begin
        if (md_op == 3'd0) begin
            a_ext_s = {{32{a[31]}}, a};
            b_ext_s = {{32{b[31]}}, b};
        end else begin
            a_ext_s = {32'd0, a};
            b_ext_s = {32'd0, b};
        end
        prod_s       = a_ext_s * b_ext_s;
        signed_div_s = (md_op == 3'd2);
        a_neg_s      = signed_div_s & a[31];
        b_neg_s      = signed_div_s & b[31];
        a_mag_s      = a_neg_s ? (32'd0 - a) : a;
        b_mag_s      = b_neg_s ? (32'd0 - b) : b;
        // A zero divisor is flagged separately; substitute 1 so the divider stays defined.
        b_safe_s     = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
        uquot_s      = a_mag_s / b_safe_s;
        urem_s       = a_mag_s % b_safe_s;
        quot_s       = (a_neg_s ^ b_neg_s) ? (32'd0 - uquot_s) : uquot_s;
        rem_s        = a_neg_s ? (32'd0 - urem_s) : urem_s;
    end

    // Next-state: countdown and commit while running, accept a new op while idle.
    always_comb begin
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                if (!div0_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end else begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
                div0_d = 1'b0;
            end else begin
                div0_d = div0_q;
            end
        end else if (start) begin
            case (md_op)
                3'd0, 3'd1: begin
                    pend_hi_d = prod_s[63:32];
                    pend_lo_d = prod_s[31:0];
                    cnt_d     = 4'(MULT_CYCLES);
                end
                3'd2, 3'd3: begin
                    pend_hi_d = rem_s;
                    pend_lo_d = quot_s;
                    div0_d    = (b == 32'd0);
                    cnt_d     = 4'(DIV_CYCLES);
                end
                3'd4:    hi_d = a;
                3'd5:    lo_d = a;
                default: cnt_d = cnt_q;
            endcase
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset mid-operation discards the pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            div0_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy     = (cnt_q != 4'd0);
    assign stall_md = md_use_D && (busy || (start && (md_op <= 3'd3)));
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the execute stage of the five-stage pipeline. It owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU as a multi-cycle operation. It exports `busy` and a decode-stage hazard flag (`stall_md`); the hazard/stall controller ORs `stall_md` into its stall term, which freezes PC and D and clears E. MFHI/MFLO read `hi`/`lo` directly in E.

## Interface
Parameters:
- `MULT_CYCLES`, 5: cycles `busy` stays high for MULT/MULTU.
- `DIV_CYCLES`, 10: cycles `busy` stays high for DIV/DIVU.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: E-stage instruction is an MD operation; sampled each rising edge.
- `md_op`  in  3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved, treated as no-op.
- `a`  in  32: forwarded rs value.
- `b`  in  32: forwarded rt value.
- `md_use_D`  in  1: D-stage instruction is one of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `busy`  out  1: multi-cycle operation in progress (registered).
- `stall_md`  out  1: combinational `md_use_D && (busy || (start && md_op<=3))`.
- `hi`  out  32: HI register (registered).
- `lo`  out  32: LO register (registered).

## Operation
- Internal state: `cnt[3:0]`, `pend_hi[31:0]`, `pend_lo[31:0]`, and `div0` (divide by zero latched).
- The state machine is IDLE when `cnt==0` and RUN when `cnt!=0`. `busy = (cnt!=0)`.
- IDLE, with `start` high and `md_op` in 0–3:
  - Compute the result from `a`/`b` this cycle and store it in `pend_hi`/`pend_lo`.
  - Load `cnt` with `MULT_CYCLES` (ops 0–1) or `DIV_CYCLES` (ops 2–3). Go to RUN.
- Arithmetic:
  - MULT: signed 32×32 to 64-bit; `{hi,lo}` = product.
  - MULTU: unsigned 32×32 to 64-bit; `{hi,lo}` = product.
  - DIV: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned. LO = quotient, HI = remainder.
  - `b==0` on DIV/DIVU: set `div0`. The full `DIV_CYCLES` still elapse, and HI/LO stay unchanged at commit.
- RUN: `cnt` decrements every edge. At the edge where `cnt==1`:
  - `cnt` goes to 0.
  - If `div0` is clear, `hi<=pend_hi` and `lo<=pend_lo`.
  - `div0` is cleared.
- IDLE, with `start` high and `md_op==4`: `hi<=a` at that edge, no busy. With `md_op==5`: `lo<=a`.
- `start` during RUN is ignored. Upstream stall guarantees this never happens; the bench still checks that state is unchanged.
- A reserved `md_op` with `start` high does nothing.
- No flush input. An operation, once started, always completes.

## Timing
- Reset (async, `rst_n` low): `hi=0`, `lo=0`, `cnt=0`, `busy=0`, `div0=0`, pending registers 0. Asserting reset mid-RUN aborts the operation with no HI/LO commit.
- Start sampled at edge T0:
  - `busy` is high in cycles T0+1 … T0+N, where N is the op's cycle count.
  - `busy` falls and the new `hi`/`lo` are visible after edge T0+N.
  - MULT busy lasts exactly 5 cycles; DIV lasts exactly 10.
- `stall_md` is high in the start cycle itself when `md_use_D` is high. This covers a back-to-back MD instruction in D.
- An MFHI/MFLO issued in D during RUN is stalled until `busy` falls, then reads the committed value in E.
- MTHI/MTLO: the new value is visible in the cycle after the start edge.
- `hi`/`lo` never change except at a commit edge, an MTHI/MTLO edge, or reset.

## Test plan
- Reset mid-operation: MULT 7×6, drop `rst_n` at T0+2 → `busy`=0 immediately; `hi`=`lo`=0 after release; no later commit.
- MULT: `a`=0xFFFFFFFE (−2), `b`=3 → `busy` high for exactly 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU with the same operands → `hi`=0x2, `lo`=0xFFFFFFFA.
- DIV/DIVU:
  - DIV `a`=−7, `b`=2 → after 10 busy cycles, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 7/2 → `lo`=3, `hi`=1.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Divide by zero: `hi`=0x11, `lo`=0x22, then DIV `b`=0 → `busy` high for 10 cycles; `hi`/`lo` stay 0x11/0x22.
- Hazard flag:
  - `start` MULT with `md_use_D`=1 → `stall_md`=1 in the start cycle and for all 5 busy cycles; 0 the cycle after `busy` falls.
  - `md_use_D`=0 while busy → `stall_md`=0.
  - A second `start` during RUN changes nothing.
- MTHI/MTLO: MTHI `a`=0xDEAD then MTLO `a`=0xBEEF on consecutive cycles → `hi`=0xDEAD, `lo`=0xBEEF, `busy` never asserts.
